shift_deserializer: RTL



---
 rtl/shift_deserializer.sv | 102 ++++++++++
 1 files changed

// File: rtl/shift_deserializer.sv
// shift_deserializer: serial-in, parallel-out shift register.
// Collects WIDTH serial bits (MSB-first or LSB-first, chosen on the first
// bit of each word) and hands the assembled word to a one-entry registered
// output slot with valid/ready backpressure.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
// Valid never depends on ready from the same side. serial_ready is
// combinational and only stalls the last bit of a word while the output
// slot is full and not draining. out_data/out_valid hold while
// out_valid && !out_ready.
module shift_deserializer #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    output logic             serial_ready,
    input  logic             direction,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic             last_bit;
    logic             eff_dir;
    logic [WIDTH-1:0] shifted;

    // Input handshake, effective direction and the shifted-in candidate word.
    always_comb begin
        serial_ready = !flush && !((cnt_q == LAST_CNT) && out_valid_q && !out_ready);
        accept       = serial_valid && serial_ready;
        last_bit     = accept && (cnt_q == LAST_CNT);
        // The first bit of a word uses the live direction input; later bits
        // use the value latched on that first bit.
        eff_dir      = (cnt_q == '0) ? direction : dir_q;
        shifted      = eff_dir ? {serial_in, sr_q[WIDTH-1:1]}
                               : {sr_q[WIDTH-2:0], serial_in};
    end

    // Next state of the shift register, bit counter and direction latch.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (flush) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (accept) begin
            sr_d  = shifted;
            dir_d = eff_dir;
            cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Next state of the output slot; a new word loading in the same cycle
    // as a drain keeps out_valid high for zero-bubble throughput.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (last_bit) begin
            out_data_d  = shifted;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign bit_count = cnt_q;

endmodule
